// File: rtl/sample_framer.sv
// sample_framer: gathers a strobed signed sample stream into FRAME_LEN-sample
// frames held in two ping-pong banks, and streams each completed frame
// downstream as a sign-extended valid/ready burst with a last marker.
// A frame is stored only while its write bank is empty. With both banks
// occupied, the incoming frame is discarded and overflow_out pulses when it
// completes. The write side never touches the bank being read.
// Optional build macro SAMPLE_FRAMER_DROP_CNT_EN adds a saturating 16-bit
// dropped-frame counter on drop_count_out.
module sample_framer #(
   parameter int FRAME_LEN  = 64,
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid_in,
   output logic [OUT_WIDTH-1:0]  m_data_out,
   output logic                  m_valid_out,
   input  logic                  m_ready_in,
   output logic                  m_last_out,
   output logic                  overflow_out
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
   ,
   output logic [15:0]           drop_count_out
`endif
);

   localparam int AW = $clog2(FRAME_LEN);
   localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      R_IDLE,
      R_LOAD,
      R_STREAM
   } rd_state_t;

   rd_state_t rd_state;
   rd_state_t rd_state_nxt;

   logic [DATA_WIDTH-1:0] mem [0:2*FRAME_LEN-1];
   logic [DATA_WIDTH-1:0] ram_q;

   logic [1:0]    full;
   logic          wr_bank;
   logic [AW-1:0] wr_ptr;
   logic          dropping;

   logic          rd_bank;
   logic [AW-1:0] rd_idx;

   logic          handshake;
   logic          release_now;
   logic          wr_free;
   logic          frame_bad;
   logic          wr_en;
   logic          wr_last;
   logic          ovf_event;
   logic          rd_addr_bank;
   logic [AW-1:0] rd_addr_idx;

   // Write-side decisions: a bank being released this cycle already counts as free
   always_comb begin
      handshake   = m_valid_out && m_ready_in;
      release_now = (rd_state == R_STREAM) && handshake && (rd_idx == LAST_IDX);
      wr_free     = !full[wr_bank] || (release_now && (rd_bank == wr_bank));
      frame_bad   = dropping || !wr_free;
      wr_last     = (wr_ptr == LAST_IDX);
      wr_en       = !rst_in && sample_valid_in && !frame_bad;
      ovf_event   = sample_valid_in && wr_last && frame_bad;
   end

   // Sample storage; contents are deliberately left unreset
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem[{wr_bank, wr_ptr}] <= sample_in;
      end
   end

   // Registered read port, one cycle of latency
   always_ff @(posedge clk_in) begin
      ram_q <= mem[{rd_addr_bank, rd_addr_idx}];
   end

   // Write pointer, bank ownership flags and the overflow pulse
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         full         <= 2'b00;
         wr_bank      <= 1'b0;
         wr_ptr       <= '0;
         dropping     <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         overflow_out <= 1'b0;
         if (release_now) begin
            full[rd_bank] <= 1'b0;
         end
         if (sample_valid_in) begin
            if (wr_last) begin
               wr_ptr   <= '0;
               dropping <= 1'b0;
               if (frame_bad) begin
                  overflow_out <= 1'b1;
               end else begin
                  full[wr_bank] <= 1'b1;
                  wr_bank       <= ~wr_bank;
               end
            end else begin
               wr_ptr   <= wr_ptr + AW'(1);
               dropping <= frame_bad;
            end
         end
      end
   end

   // Read FSM next state and read address; the address runs one word ahead
   always_comb begin
      rd_state_nxt = rd_state;
      rd_addr_bank = rd_bank;
      rd_addr_idx  = rd_idx + AW'(1);
      case (rd_state)
         R_IDLE: begin
            rd_addr_idx = '0;
            if (full[rd_bank]) begin
               rd_state_nxt = R_LOAD;
            end
         end
         R_LOAD: begin
            rd_addr_idx  = AW'(1);
            rd_state_nxt = R_STREAM;
         end
         R_STREAM: begin
            if (handshake) begin
               if (rd_idx == LAST_IDX) begin
                  rd_addr_bank = ~rd_bank;
                  rd_addr_idx  = '0;
                  rd_state_nxt = full[~rd_bank] ? R_LOAD : R_IDLE;
               end else begin
                  rd_addr_idx = rd_idx + AW'(2);
               end
            end
         end
         default: begin
            rd_state_nxt = R_IDLE;
         end
      endcase
   end

   // Read FSM state register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_state <= R_IDLE;
      end else begin
         rd_state <= rd_state_nxt;
      end
   end

   // Output word register: load word 0, advance on handshake, drop after the last beat
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_bank     <= 1'b0;
         rd_idx      <= '0;
         m_data_out  <= '0;
         m_valid_out <= 1'b0;
         m_last_out  <= 1'b0;
      end else begin
         case (rd_state)
            R_LOAD: begin
               m_data_out  <= OUT_WIDTH'($signed(ram_q));
               m_valid_out <= 1'b1;
               m_last_out  <= 1'b0;
               rd_idx      <= '0;
            end
            R_STREAM: begin
               if (handshake) begin
                  if (rd_idx == LAST_IDX) begin
                     m_valid_out <= 1'b0;
                     m_last_out  <= 1'b0;
                     rd_bank     <= ~rd_bank;
                  end else begin
                     m_data_out <= OUT_WIDTH'($signed(ram_q));
                     rd_idx     <= rd_idx + AW'(1);
                     m_last_out <= (rd_idx == (LAST_IDX - AW'(1)));
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SAMPLE_FRAMER_DROP_CNT_EN
   // Saturating count of dropped frames
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_count_out <= 16'h0000;
      end else if (ovf_event && (drop_count_out != 16'hFFFF)) begin
         drop_count_out <= drop_count_out + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed bench for sample_framer with a cycle-stepped
// driver and an in-order beat scoreboard fed with hand-chosen sample patterns.
// Honours SAMPLE_FRAMER_DROP_CNT_EN when the design is built with it.
module tb_sample_framer;

   localparam int FRAME_LEN  = 64;
   localparam int DATA_WIDTH = 8;
   localparam int OUT_WIDTH  = 16;

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic [DATA_WIDTH-1:0] sample_in;
   logic                  sample_valid_in;
   logic [OUT_WIDTH-1:0]  m_data_out;
   logic                  m_valid_out;
   logic                  m_ready_in;
   logic                  m_last_out;
   logic                  overflow_out;
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
   logic [15:0]           drop_count_out;
`endif

   int total_checks = 0;
   int bad_checks   = 0;

   logic [31:0] exp_mem [0:4095];
   int exp_wr    = 0;
   int exp_rd    = 0;
   int beat_no   = 0;
   int ovf_count = 0;
   int gap_low   = 0;
   int ready_mode = 1;
   logic stall_prev = 1'b0;
   logic [15:0] held_data = '0;
   logic held_last = 1'b0;

   sample_framer #(
      .FRAME_LEN(FRAME_LEN),
      .DATA_WIDTH(DATA_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .sample_in(sample_in),
      .sample_valid_in(sample_valid_in),
      .m_data_out(m_data_out),
      .m_valid_out(m_valid_out),
      .m_ready_in(m_ready_in),
      .m_last_out(m_last_out),
      .overflow_out(overflow_out)
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
      ,
      .drop_count_out(drop_count_out)
`endif
   );

   // Free-running clock
   always #5 clk_in = ~clk_in;

   // Hard stop in case something wedges
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sampleVal(input int pat, input int k);
      case (pat)
         0:       return 8'(k);
         1:       return (k == 0) ? 8'h80 : (k == 1) ? 8'h7F : 8'(k * 29 + 3);
         2:       return 8'(255 - k);
         3:       return 8'(k + 100);
         default: return 8'(k * 5 + 1);
      endcase
   endfunction

   function automatic logic [31:0] expWord(input logic [7:0] b);
      return {16'h0000, {8{b[7]}}, b};
   endfunction

   task automatic pushExp(input logic [31:0] w);
      exp_mem[exp_wr] = w;
      exp_wr++;
   endtask

   // Scoreboard step, evaluated 1 time unit after an edge with this cycle's inputs applied
   task automatic observe();
      logic [31:0] e;
      if (rst_in) begin
         exp_rd     = exp_wr;
         beat_no    = 0;
         stall_prev = 1'b0;
         return;
      end
      if (stall_prev) begin
         checkOutput("hold_valid", 32'(m_valid_out), 32'd1);
         checkOutput("hold_data", 32'(m_data_out), 32'(held_data));
         checkOutput("hold_last", 32'(m_last_out), 32'(held_last));
      end
      if (m_last_out && !m_valid_out) begin
         checkOutput("last_needs_valid", 32'(m_valid_out), 32'd1);
      end
      if (m_valid_out && m_ready_in) begin
         e = (exp_rd < exp_wr) ? exp_mem[exp_rd] : 32'h0001_0000;
         checkOutput($sformatf("beat%0d_data", beat_no), 32'(m_data_out), e);
         checkOutput($sformatf("beat%0d_last", beat_no), 32'(m_last_out),
                     32'((beat_no % FRAME_LEN) == FRAME_LEN - 1));
         if (exp_rd < exp_wr) exp_rd++;
         beat_no++;
      end else if (!m_valid_out && beat_no > 0 && exp_rd < exp_wr) begin
         gap_low++;
      end
      if (overflow_out) ovf_count++;
      stall_prev = m_valid_out && !m_ready_in;
      held_data  = m_data_out;
      held_last  = m_last_out;
   endtask

   // Drive one cycle of inputs, score it, then advance past the next edge
   task automatic applyStimulus(input logic [7:0] s, input logic v);
      sample_in       = s;
      sample_valid_in = v;
      case (ready_mode)
         0:       m_ready_in = 1'b0;
         1:       m_ready_in = 1'b1;
         default: m_ready_in = ~m_ready_in;
      endcase
      observe();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0);
   endtask

   task automatic sendFrame(input int pat, input bit keep, input int count);
      for (int k = 0; k < count; k++) begin
         if (keep) begin
            if (pat == 1 && k == 0)      pushExp(32'h0000_FF80);
            else if (pat == 1 && k == 1) pushExp(32'h0000_007F);
            else                         pushExp(expWord(sampleVal(pat, k)));
         end
         applyStimulus(sampleVal(pat, k), 1'b1);
      end
      sample_valid_in = 1'b0;
   endtask

   task automatic waitDrain(input int max_cycles, input string tag);
      for (int i = 0; i < max_cycles && exp_rd < exp_wr; i++) applyStimulus(8'h00, 1'b0);
      checkOutput(tag, 32'(exp_wr - exp_rd), 32'd0);
   endtask

   task automatic doReset();
      rst_in = 1'b1;
      applyStimulus(8'h55, 1'b1);
      checkOutput("rst_valid", 32'(m_valid_out), 32'd0);
      checkOutput("rst_data", 32'(m_data_out), 32'd0);
      checkOutput("rst_last", 32'(m_last_out), 32'd0);
      checkOutput("rst_ovf", 32'(overflow_out), 32'd0);
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
      checkOutput("rst_drop_count", 32'(drop_count_out), 32'd0);
`endif
      rst_in = 1'b0;
      sample_valid_in = 1'b0;
   endtask

   initial begin
      int base;
      rst_in          = 1'b1;
      sample_in       = '0;
      sample_valid_in = 1'b0;
      m_ready_in      = 1'b0;
      @(posedge clk_in);
      #1;
      doReset();

      // Ramp frame with ready high; first valid two edges after the final strobe
      ready_mode = 1;
      sendFrame(0, 1'b1, FRAME_LEN);
      checkOutput("t1_lat_edge0", 32'(m_valid_out), 32'd0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("t1_lat_edge1", 32'(m_valid_out), 32'd0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("t1_lat_edge2", 32'(m_valid_out), 32'd1);
      checkOutput("t1_first_word", 32'(m_data_out), 32'd0);
      waitDrain(200, "t1_drained");
      checkOutput("t1_beats", 32'(beat_no), 32'd64);

      // Extremes of the signed range
      sendFrame(1, 1'b1, FRAME_LEN);
      waitDrain(200, "t2_drained");
      checkOutput("t2_beats", 32'(beat_no), 32'd128);

      // Ready toggling every cycle across two consecutive frames
      ready_mode = 2;
      sendFrame(2, 1'b1, FRAME_LEN);
      sendFrame(3, 1'b1, FRAME_LEN);
      waitDrain(600, "t3_drained");
      checkOutput("t3_beats", 32'(beat_no), 32'd256);
      checkOutput("t3_no_ovf", 32'(ovf_count), 32'd0);

      // Stalled downstream: two frames stored, the third dropped
      doReset();
      base = ovf_count;
      ready_mode = 0;
      sendFrame(3, 1'b1, FRAME_LEN);
      sendFrame(4, 1'b1, FRAME_LEN);
      idle(3);
      checkOutput("t4_ovf_after_f2", 32'(ovf_count - base), 32'd0);
      sendFrame(2, 1'b0, FRAME_LEN);
      checkOutput("t4_ovf_pulse", 32'(overflow_out), 32'd1);
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
      checkOutput("t4_drop_count", 32'(drop_count_out), 32'd1);
`endif
      applyStimulus(8'h00, 1'b0);
      checkOutput("t4_ovf_single", 32'(overflow_out), 32'd0);
      idle(5);
      checkOutput("t4_ovf_count", 32'(ovf_count - base), 32'd1);
      gap_low = 0;
      ready_mode = 1;
      waitDrain(400, "t4_drained");
      checkOutput("t4_beats", 32'(beat_no), 32'd128);
      checkOutput("t4_gap_cycles", 32'(gap_low), 32'd1);

      // Reset part way through a frame being written
      doReset();
      sendFrame(4, 1'b0, 30);
      doReset();
      sendFrame(4, 1'b1, FRAME_LEN);
      waitDrain(200, "t5a_drained");
      checkOutput("t5a_beats", 32'(beat_no), 32'd64);

      // Reset part way through a burst
      base = beat_no;
      sendFrame(3, 1'b1, FRAME_LEN);
      for (int i = 0; i < 200 && (beat_no - base) < 10; i++) applyStimulus(8'h00, 1'b0);
      checkOutput("t5b_at_beat10", 32'(beat_no - base), 32'd10);
      doReset();
      sendFrame(2, 1'b1, FRAME_LEN);
      waitDrain(200, "t5b_drained");
      checkOutput("t5b_beats", 32'(beat_no), 32'd64);

      // Second bank completes on the very edge the first bank's last beat is taken
      doReset();
      base = ovf_count;
      ready_mode = 0;
      sendFrame(0, 1'b1, FRAME_LEN);
      sendFrame(1, 1'b1, FRAME_LEN - 1);
      ready_mode = 1;
      idle(FRAME_LEN - 1);
      checkOutput("t6_align_last", 32'(m_last_out), 32'd1);
      checkOutput("t6_align_beats", 32'(beat_no), 32'd63);
      pushExp(expWord(sampleVal(1, FRAME_LEN - 1)));
      applyStimulus(sampleVal(1, FRAME_LEN - 1), 1'b1);
      sample_valid_in = 1'b0;
      checkOutput("t6_no_ovf_pulse", 32'(overflow_out), 32'd0);
      waitDrain(200, "t6_drained");
      checkOutput("t6_beats", 32'(beat_no), 32'd128);
      checkOutput("t6_ovf_count", 32'(ovf_count - base), 32'd0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
